// File: rtl/dcache_pkg.sv
// Shared constants and FSM state type for the direct-mapped data cache.
package dcache_pkg;
    localparam int unsigned LINES      = 8;
    localparam int unsigned INDEX_W    = 3;
    localparam int unsigned TAG_W      = 3;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned MEM_ADDR_W = 6;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;
endpackage

// File: rtl/dcache_store.sv
// Line storage: data/tag arrays (never reset) plus valid/dirty flags (reset).
module dcache_store
    import dcache_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic [INDEX_W-1:0] index,
    input  logic               write_hit,
    input  logic [WORD_W-1:0]  write_word,
    input  logic               fill,
    input  logic [WORD_W-1:0]  fill_word,
    input  logic [TAG_W-1:0]   fill_tag,
    output logic [WORD_W-1:0]  line_data,
    output logic [TAG_W-1:0]   line_tag,
    output logic               line_valid,
    output logic               line_dirty
);
    logic [WORD_W-1:0] data [LINES];
    logic [TAG_W-1:0]  tag  [LINES];
    logic [LINES-1:0]  valid;
    logic [LINES-1:0]  dirty;

    // Data and tag arrays: fill has priority over a store hit; no reset.
    always_ff @(posedge clock) begin
        if (fill) begin
            data[index] <= fill_word;
            tag[index]  <= fill_tag;
        end else if (write_hit) begin
            data[index] <= write_word;
        end
    end

    // Valid/dirty flags: cleared by reset, set/cleared by fill and store hits.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid <= '0;
            dirty <= '0;
        end else if (fill) begin
            valid[index] <= 1'b1;
            dirty[index] <= 1'b0;
        end else if (write_hit) begin
            dirty[index] <= 1'b1;
        end
    end

    assign line_data  = data[index];
    assign line_tag   = tag[index];
    assign line_valid = valid[index];
    assign line_dirty = dirty[index];
endmodule

// File: rtl/dcache.sv
// Direct-mapped write-back, write-allocate data cache: hit logic and miss FSM.
module dcache
    import dcache_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  read,
    input  logic                  write,
    input  logic [7:0]            address,
    input  logic [WORD_W-1:0]     writedata,
    output logic [WORD_W-1:0]     readdata,
    output logic                  busywait,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [MEM_ADDR_W-1:0] mem_address,
    output logic [WORD_W-1:0]     mem_writedata,
    input  logic [WORD_W-1:0]     mem_readdata,
    input  logic                  mem_busywait
);
    state_t             state;
    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   req_tag;
    logic [WORD_W-1:0]  line_data;
    logic [TAG_W-1:0]   line_tag;
    logic               line_valid;
    logic               line_dirty;
    logic               access;
    logic               hit;
    logic               write_hit;
    logic               fill;

    assign index   = address[4:2];
    assign req_tag = address[7:5];
    // read and write together count as no access at all
    assign access  = read ^ write;
    assign hit     = line_valid && (line_tag == req_tag);

    assign busywait  = access && !(state == IDLE && hit);
    assign write_hit = (state == IDLE) && write && !read && hit && !reset;
    assign fill      = (state == ALLOCATE) && !mem_busywait && !reset;
    assign readdata  = line_data;

    dcache_store u_store (
        .clock      (clock),
        .reset      (reset),
        .index      (index),
        .write_hit  (write_hit),
        .write_word (writedata),
        .fill       (fill),
        .fill_word  (mem_readdata),
        .fill_tag   (req_tag),
        .line_data  (line_data),
        .line_tag   (line_tag),
        .line_valid (line_valid),
        .line_dirty (line_dirty)
    );

    // Miss FSM; memory request outputs are registered on state entry so they
    // stay stable for the whole request.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (access && !hit) begin
                        if (line_valid && line_dirty) begin
                            state         <= WRITEBACK;
                            mem_write     <= 1'b1;
                            mem_address   <= {line_tag, index};
                            mem_writedata <= line_data;
                        end else begin
                            state       <= ALLOCATE;
                            mem_read    <= 1'b1;
                            mem_address <= address[7:2];
                        end
                    end
                end
                WRITEBACK: begin
                    if (!mem_busywait) begin
                        state       <= ALLOCATE;
                        mem_write   <= 1'b0;
                        mem_read    <= 1'b1;
                        mem_address <= address[7:2];
                    end
                end
                ALLOCATE: begin
                    if (!mem_busywait) begin
                        state    <= IDLE;
                        mem_read <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dcache.sv
// Directed testbench for dcache with a simple word-addressed memory model.
module tb_dcache;
    logic        clock = 1'b0;
    logic        reset;
    logic        read;
    logic        write;
    logic [7:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        busywait;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;

    logic [31:0] mem [64];
    int errors = 0;
    int checks = 0;

    dcache dut (
        .clock         (clock),
        .reset         (reset),
        .read          (read),
        .write         (write),
        .address       (address),
        .writedata     (writedata),
        .readdata      (readdata),
        .busywait      (busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
    );

    always #5 clock = ~clock;

    // Memory model: loaded while reset is high, written on accepted mem_write.
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hA000_0000 + i;
            mem[0] <= 32'h00FF_0000;
        end else if (mem_write && !mem_busywait) begin
            mem[mem_address] <= mem_writedata;
        end
    end
    assign mem_readdata = mem[mem_address];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    initial begin
        reset = 1'b1; read = 1'b0; write = 1'b0; address = 8'h00;
        writedata = '0; mem_busywait = 1'b0;
        step(); step();
        reset = 1'b0;
        #1;
        check("rst_busywait", busywait, 0);
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_write", mem_write, 0);

        // Clean read miss at 0x00
        read = 1'b1; address = 8'h00;
        #1;
        check("rd0_busy_miss", busywait, 1);
        check("rd0_idle_no_req", mem_read, 0);
        step();
        check("rd0_alloc_mem_read", mem_read, 1);
        check("rd0_alloc_addr", mem_address, 0);
        check("rd0_alloc_busy", busywait, 1);
        step();
        check("rd0_hit_busy", busywait, 0);
        check("rd0_readdata", readdata, 32'h00FF_0000);
        check("rd0_req_dropped", mem_read, 0);

        // Write miss at 0x04: one fill, then the store hits
        read = 1'b0; write = 1'b1; address = 8'h04; writedata = 32'h1234_5678;
        #1;
        check("wr4_busy_miss", busywait, 1);
        step();
        check("wr4_alloc_addr", mem_address, 1);
        check("wr4_alloc_mem_read", mem_read, 1);
        step();
        check("wr4_hit_busy", busywait, 0);
        check("wr4_filled", readdata, 32'hA000_0001);
        step();
        check("wr4_committed", readdata, 32'h1234_5678);
        write = 1'b0; read = 1'b1;
        #1;
        check("rd4_busy", busywait, 0);
        check("rd4_readdata", readdata, 32'h1234_5678);
        check("rd4_mem_unchanged", mem[1], 32'hA000_0001);

        // Dirty conflict miss at 0x24: write-back then fill
        address = 8'h24;
        #1;
        check("rd24_busy_miss", busywait, 1);
        step();
        check("rd24_wb_mem_write", mem_write, 1);
        check("rd24_wb_mem_read", mem_read, 0);
        check("rd24_wb_addr", mem_address, 1);
        check("rd24_wb_data", mem_writedata, 32'h1234_5678);
        step();
        check("rd24_alloc_mem_write", mem_write, 0);
        check("rd24_alloc_mem_read", mem_read, 1);
        check("rd24_alloc_addr", mem_address, 9);
        check("rd24_mem1_written", mem[1], 32'h1234_5678);
        step();
        check("rd24_hit_busy", busywait, 0);
        check("rd24_readdata", readdata, 32'hA000_0009);

        // read and write together: no access
        read = 1'b1; write = 1'b1; address = 8'h08; writedata = 32'hDEAD_BEEF;
        #1;
        check("both_busy", busywait, 0);
        step();
        check("both_mem_read", mem_read, 0);
        check("both_mem_write", mem_write, 0);
        write = 1'b0;
        #1;
        check("both_line_still_invalid", busywait, 1);

        // Long fill: memory busy for 10 cycles
        mem_busywait = 1'b1;
        step();
        for (int i = 0; i < 10; i++) begin
            check("slow_addr", mem_address, 2);
            check("slow_mem_read", mem_read, 1);
            check("slow_busy", busywait, 1);
            step();
        end
        mem_busywait = 1'b0;
        step();
        check("slow_hit_busy", busywait, 0);
        check("slow_readdata", readdata, 32'hA000_0002);

        // Reset during ALLOCATE aborts the fill and invalidates all lines
        address = 8'h0C;
        step();
        check("abort_alloc_mem_read", mem_read, 1);
        reset = 1'b1; read = 1'b0;
        step();
        reset = 1'b0;
        #1;
        check("abort_mem_read", mem_read, 0);
        check("abort_mem_write", mem_write, 0);
        check("abort_busy_idle", busywait, 0);
        read = 1'b1; address = 8'h00;
        #1;
        check("abort_rd0_miss", busywait, 1);
        step();
        check("abort_rd0_alloc", mem_read, 1);
        check("excl_final", mem_read & mem_write, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
